upc_tag_tx: RTL and testbench
=============================

UPC_TAG_TX -- requirements
Module: upc_tag_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to send one tag frame; sampled only while ready=1.
REQ-005 upc  input  3  UPC code to send, upc[2] first.
REQ-006 mark  input  1  security-mark bit sent after the UPC code.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 busy  output  1  high while a frame is on the line; always equals ~ready.
REQ-009 done  output  1  one-cycle pulse when a frame completes.
REQ-010 tx_out  output  1  serial line; idles high.

Function
REQ-011 Frame SHALL be 7 bits, in order: start(0), upc[2], upc[1], upc[0], mark, parity, stop(1).
REQ-012 Parity SHALL be even: parity = upc[2]^upc[1]^upc[0]^mark.
REQ-013 Each bit SHALL be held on tx_out for exactly CLKS_PER_BIT cycles.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE->START when start=1 at a rising edge; START->DATA, DATA->PARITY after 4 bit periods, PARITY->STOP, STOP->IDLE, each after its bit period(s).
REQ-016 upc and mark SHALL be captured into a shift register on the accepting edge; later input changes SHALL NOT affect the frame in flight.
REQ-017 tx_out SHALL be registered: start accepted at edge N -> tx_out=0 during cycles N+1..N+CLKS_PER_BIT.
REQ-018 done SHALL be high for exactly one cycle: the first IDLE cycle after the last stop-bit cycle (cycle N+7*CLKS_PER_BIT+1).
REQ-019 ready SHALL be high in the done cycle; start asserted then SHALL begin a new frame back-to-back with no extra idle bit.
REQ-020 start while busy=1 SHALL be ignored and not queued.
REQ-021 start held high continuously SHALL send consecutive frames, one per acceptance.
REQ-022 A 3-bit data-bit counter SHALL count 0..3 in DATA; a bit timer SHALL count 0..CLKS_PER_BIT-1 and wrap.

Reset
REQ-023 With reset=1 at an edge: state=IDLE, tx_out=1, ready=1, busy=0, done=0, counters=0, shift register=0.
REQ-024 Reset SHALL take priority over start in the same cycle.
REQ-025 Reset mid-frame SHALL abort the frame; tx_out returns high the next cycle, and no done pulse for the aborted frame.

Structure
REQ-026 Package upc_pkg SHALL hold the state enum typedef, FRAME_BITS=7, DATA_BITS=4, and the CLKS_PER_BIT default.
REQ-027 One sub-module, bit_timer, SHALL implement the bit-period counter with a clear input and a one-cycle tick output at count CLKS_PER_BIT-1.
REQ-028 upc_tag_tx SHALL contain only the FSM, shift register, parity, and data-bit counter.

Verification (CLKS_PER_BIT=4, start accepted at edge 0)
REQ-029 upc=101, mark=0 -> tx_out by 4-cycle bit: 0,1,0,1,0,0,1 over cycles 1..28; done=1 only in cycle 29.
REQ-030 upc=100, mark=0 -> parity bit=1 (cycles 21..24); upc=111, mark=1 -> parity bit=0.
REQ-031 start pulsed again at cycles 5 and 20 with different upc -> ignored; frame unchanged; one done pulse.
REQ-032 start held high -> second frame's start bit at cycles 30..33; done pulses at 29 and 58 only.
REQ-033 reset=1 at cycle 12 -> tx_out=1, ready=1 from cycle 13; no done pulse; next start sends a full, correct frame.
REQ-034 start and reset both high at the same edge -> remains IDLE, tx_out=1, no frame.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared types and constants for the UPC security-tag serial transmitter.
package upc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int FRAME_BITS           = 7;
   localparam int DATA_BITS            = 4;
   localparam int CLKS_PER_BIT_DEFAULT = 4;
   // Payload plus parity: everything between the start and stop bits.
   localparam int SHIFT_BITS           = FRAME_BITS - 2;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and ticks on the last count.
module bit_timer
   import upc_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/upc_tag_tx.sv
// Serial transmitter for 7-bit UPC tag frames: start, upc[2:0], mark, even parity, stop.
module upc_tag_tx
   import upc_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] upc,
   input  logic       mark,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       tx_out
);

   state_t                state;
   state_t                state_next;
   logic                  tick;
   logic                  timer_clear;
   logic                  accept;
   logic                  last_data;
   logic                  tx_next;
   logic                  done_next;
   logic [2:0]            bit_cnt;
   logic [2:0]            bit_cnt_next;
   logic [SHIFT_BITS-1:0] shift;
   logic [SHIFT_BITS-1:0] shift_next;

   // Holding the timer clear while idle aligns its first count with the start bit.
   assign timer_clear = (state == IDLE);
   assign accept      = (state == IDLE) && start;
   assign last_data   = (bit_cnt == 3'(DATA_BITS - 1));

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)             state_next = START;  else state_next = IDLE;
         START:   if (tick)              state_next = DATA;   else state_next = START;
         DATA:    if (tick && last_data) state_next = PARITY; else state_next = DATA;
         PARITY:  if (tick)              state_next = STOP;   else state_next = PARITY;
         STOP:    if (tick)              state_next = IDLE;   else state_next = STOP;
         default: state_next = IDLE;
      endcase
   end

   // Parity rides in the shift register so PARITY simply sends the MSB after the last shift.
   always_comb begin
      shift_next   = shift;
      bit_cnt_next = bit_cnt;
      if (accept) begin
         shift_next   = {upc, mark, even_parity({upc, mark})};
         bit_cnt_next = 3'd0;
      end else if ((state == DATA) && tick) begin
         shift_next   = {shift[SHIFT_BITS-2:0], 1'b0};
         bit_cnt_next = last_data ? 3'd0 : bit_cnt + 3'd1;
      end else begin
         shift_next   = shift;
         bit_cnt_next = bit_cnt;
      end
   end

   always_comb begin
      tx_next   = 1'b1;
      done_next = (state == STOP) && tick;
      case (state_next)
         IDLE:    tx_next = 1'b1;
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[SHIFT_BITS-1];
         PARITY:  tx_next = shift_next[SHIFT_BITS-1];
         STOP:    tx_next = 1'b1;
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift   <= '0;
         bit_cnt <= 3'd0;
         tx_out  <= 1'b1;
         done    <= 1'b0;
      end else begin
         shift   <= shift_next;
         bit_cnt <= bit_cnt_next;
         tx_out  <= tx_next;
         done    <= done_next;
      end
   end

   assign ready = (state == IDLE);
   assign busy  = ~ready;

endmodule

// File: tb/tb_upc_tag_tx.sv
// Scoreboard bench for upc_tag_tx: a line receiver decodes frames and compares them to queued expectations.
module tb_upc_tag_tx;

   localparam int C            = 4;
   localparam int FRAME_CYCLES = 7 * C;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       mark  = 1'b0;
   logic [2:0] upc   = 3'b000;
   logic       ready;
   logic       busy;
   logic       done;
   logic       tx_out;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         done_cnt = 0;
   int         rx_k     = -1;
   logic [6:0] rx_bits  = 7'h00;
   logic [6:0] exp_q[$];

   always #5 clk = ~clk;

   upc_tag_tx #(.CLKS_PER_BIT(C)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .upc    (upc),
      .mark   (mark),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .tx_out (tx_out)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] frame_of(input logic [2:0] u, input logic m);
      logic p;
      p = u[2] ^ u[1] ^ u[0] ^ m;
      return {1'b0, u, m, p, 1'b1};
   endfunction

   // A reset seen by the DUT aborts whatever frame the receiver was collecting.
   always @(posedge clk) begin
      if (reset && rx_k >= 0) begin
         rx_k = -1;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   // Line receiver: samples every cycle, checks each bit is held C cycles, then expects done.
   always @(negedge clk) begin
      logic [6:0] e;
      check_eq("busy_vs_ready", int'(busy ^ ready), 1);
      if (done === 1'b1) done_cnt++;
      if (rx_k == FRAME_CYCLES) begin
         check_eq("done_pulse", int'(done), 1);
         check_eq("ready_at_done", int'(ready), 1);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
         check_eq("frame_bits", int'(rx_bits), int'(e));
         rx_k = -1;
      end else begin
         check_eq("done_idle", int'(done), 0);
         if (rx_k < 0 && tx_out === 1'b0) rx_k = 0;
         if (rx_k >= 0) begin
            if (rx_k % C == 0) rx_bits = {rx_bits[5:0], tx_out};
            else check_eq("bit_hold", int'(tx_out), int'(rx_bits[0]));
            rx_k++;
         end
      end
   end

   task automatic run_frame(input logic [2:0] u, input logic m);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      upc = u; mark = m; start = 1'b1;
      exp_q.push_back(frame_of(u, m));
      @(negedge clk);
      start = 1'b0; upc = ~u; mark = ~m;
      check_eq("start_bit_c1", int'(tx_out), 0);
      repeat (20) @(negedge clk);
      check_eq("parity_c21", int'(tx_out), int'(u[2] ^ u[1] ^ u[0] ^ m));
      repeat (7) @(negedge clk);
      check_eq("stop_bit_c28", int'(tx_out), 1);
      @(negedge clk);
      check_eq("done_c29", int'(done), 1);
      @(negedge clk);
      check_eq("done_count", done_cnt - d0, 1);
   endtask

   initial begin
      int d0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx", int'(tx_out), 1);
      check_eq("rst_ready", int'(ready), 1);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      reset = 1'b0;
      @(negedge clk);

      run_frame(3'b101, 1'b0);
      run_frame(3'b100, 1'b0);
      run_frame(3'b111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         run_frame(3'($urandom_range(7)), 1'($urandom_range(1)));
      end

      // Starts while busy are dropped.
      d0 = done_cnt;
      @(negedge clk); upc = 3'b101; mark = 1'b0; start = 1'b1;
      exp_q.push_back(frame_of(3'b101, 1'b0));
      @(negedge clk); start = 1'b0; upc = 3'b000;
      repeat (4) @(negedge clk);
      start = 1'b1; upc = 3'b010; mark = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (14) @(negedge clk);
      start = 1'b1; upc = 3'b011;
      @(negedge clk); start = 1'b0;
      repeat (19) @(negedge clk);
      check_eq("busy_start_one_done", done_cnt - d0, 1);
      check_eq("busy_start_not_queued", exp_q.size(), 0);

      // start held high: back-to-back frames.
      d0 = done_cnt;
      @(negedge clk); start = 1'b1; upc = 3'b110; mark = 1'b1;
      exp_q.push_back(frame_of(3'b110, 1'b1));
      for (int c = 1; c <= 29; c++) begin
         @(negedge clk);
         if (c == 10) begin upc = 3'b011; mark = 1'b0; end
         if (c == 29) exp_q.push_back(frame_of(3'b011, 1'b0));
      end
      @(negedge clk); start = 1'b0;
      check_eq("b2b_start_c30", int'(tx_out), 0);
      repeat (3) @(negedge clk);
      check_eq("b2b_start_c33", int'(tx_out), 0);
      @(negedge clk);
      check_eq("b2b_upc2_c34", int'(tx_out), 0);
      repeat (24) @(negedge clk);
      check_eq("b2b_done_c58", int'(done), 1);
      @(negedge clk);
      check_eq("b2b_done_count", done_cnt - d0, 2);

      // Reset mid-frame aborts it.
      d0 = done_cnt;
      @(negedge clk); start = 1'b1; upc = 3'b011; mark = 1'b1;
      exp_q.push_back(frame_of(3'b011, 1'b1));
      @(negedge clk); start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check_eq("abort_tx_high", int'(tx_out), 1);
      check_eq("abort_ready", int'(ready), 1);
      check_eq("abort_busy", int'(busy), 0);
      repeat (20) @(negedge clk);
      check_eq("abort_no_done", done_cnt - d0, 0);
      check_eq("abort_sb_flushed", exp_q.size(), 0);
      run_frame(3'b011, 1'b1);

      // Reset wins over start at the same edge.
      d0 = done_cnt;
      @(negedge clk); reset = 1'b1; start = 1'b1; upc = 3'b101;
      @(negedge clk); reset = 1'b0; start = 1'b0;
      check_eq("rst_start_tx", int'(tx_out), 1);
      check_eq("rst_start_ready", int'(ready), 1);
      repeat (12) @(negedge clk);
      check_eq("rst_start_tx_later", int'(tx_out), 1);
      check_eq("rst_start_no_done", done_cnt - d0, 0);

      check_eq("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
